// File: rtl/icache_pkg.sv
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types and constants for the direct-mapped
//                instruction cache (controller state encoding, word geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    // Controller states; 2-bit encoding shared with the rest of the core.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFILL  = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    // Byte-offset bits inside one 32-bit word.
    localparam int c_word_byte_bits = 2;

endpackage : icache_pkg

`default_nettype wire

// File: rtl/icache_line_ram.sv
// ============================================================================
//  Module      : icache_line_ram
//  Description : Valid/tag/data storage for the instruction cache. One
//                combinational read port (valid, tag, one word), one
//                synchronous word-write port and a per-line valid clear/set
//                port that also writes the tag on set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_line_ram #(
    parameter int INDEX_WIDTH    = 6,
    parameter int LINE_WORDS_LOG = 2,
    parameter int TAG_WIDTH      = 22
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INDEX_WIDTH-1:0]    i_rd_index,
    input  logic [LINE_WORDS_LOG-1:0] i_rd_offset,
    output logic                      o_rd_valid,
    output logic [TAG_WIDTH-1:0]      o_rd_tag,
    output logic [31:0]               o_rd_word,
    input  logic                      i_wr_en,
    input  logic [INDEX_WIDTH-1:0]    i_wr_index,
    input  logic [LINE_WORDS_LOG-1:0] i_wr_offset,
    input  logic [31:0]               i_wr_data,
    input  logic                      i_vld_clr,
    input  logic                      i_vld_set,
    input  logic [INDEX_WIDTH-1:0]    i_vld_index,
    input  logic [TAG_WIDTH-1:0]      i_set_tag
);

    localparam int c_lines = 1 << INDEX_WIDTH;
    localparam int c_words = c_lines << LINE_WORDS_LOG;

    logic [c_lines-1:0]   r_valid_q;
    logic [c_lines-1:0]   w_valid_d;
    logic [TAG_WIDTH-1:0] r_tag_q  [c_lines];
    logic [31:0]          r_data_q [c_words];

    // Next valid vector: a set wins over a clear of the same line.
    always_comb begin
        w_valid_d = r_valid_q;
        if (i_vld_clr) w_valid_d[i_vld_index] = 1'b0;
        if (i_vld_set) w_valid_d[i_vld_index] = 1'b1;
    end

    // Valid bits are the only storage that needs a reset.
    always_ff @(posedge clk) begin
        if (rst) r_valid_q <= '0;
        else     r_valid_q <= w_valid_d;
    end

    // Tag is written together with the valid set at the end of a refill.
    always_ff @(posedge clk) begin
        if (i_vld_set) r_tag_q[i_vld_index] <= i_set_tag;
    end

    // One refill word per write; words of a line are stored contiguously.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_data_q[{i_wr_index, i_wr_offset}] <= i_wr_data;
    end

    assign o_rd_valid = r_valid_q[i_rd_index];
    assign o_rd_tag   = r_tag_q[i_rd_index];
    assign o_rd_word  = r_data_q[{i_rd_index, i_rd_offset}];

endmodule : icache_line_ram

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped, read-only instruction cache. Serves ifetch
//                word lookups with one-cycle hit latency and refills whole
//                lines from mem_ctrl one word per request on a miss.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH    = 6,
    parameter int LINE_WORDS_LOG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] IF_addr,
    input  logic        IF_addr_sgn,
    input  logic        IF_pc_change,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data
);

    localparam int TAG_WIDTH = 32 - c_word_byte_bits - LINE_WORDS_LOG - INDEX_WIDTH;
    localparam int c_idx_lo  = LINE_WORDS_LOG + c_word_byte_bits;
    localparam int c_tag_lo  = INDEX_WIDTH + c_idx_lo;
    localparam logic [LINE_WORDS_LOG-1:0] c_last_word = '1;

    state_e                    r_state_q,   w_state_d;
    logic                      r_ins_sgn_q, w_ins_sgn_d;
    logic [31:0]               r_ins_q,     w_ins_d;
    logic                      r_mc_req_q,  w_mc_req_d;
    logic [31:0]               r_mc_addr_q, w_mc_addr_d;
    logic [LINE_WORDS_LOG-1:0] r_cnt_q,     w_cnt_d;
    logic                      r_abort_q,   w_abort_d;

    logic                      w_rd_valid;
    logic [TAG_WIDTH-1:0]      w_rd_tag;
    logic [31:0]               w_rd_word;
    logic                      w_wr_en;
    logic                      w_vld_clr;
    logic                      w_vld_set;
    logic [INDEX_WIDTH-1:0]    w_vld_index;
    logic                      w_hit;
    logic                      w_unused_addr;

    // Request address split; the fill line is taken from MC_addr, which
    // always points inside the line being refilled.
    logic [INDEX_WIDTH-1:0]    w_req_index;
    logic [LINE_WORDS_LOG-1:0] w_req_offset;
    logic [TAG_WIDTH-1:0]      w_req_tag;
    logic [INDEX_WIDTH-1:0]    w_fill_index;
    logic [TAG_WIDTH-1:0]      w_fill_tag;

    assign w_req_index   = IF_addr[c_tag_lo-1:c_idx_lo];
    assign w_req_offset  = IF_addr[c_idx_lo-1:c_word_byte_bits];
    assign w_req_tag     = IF_addr[31:c_tag_lo];
    assign w_fill_index  = r_mc_addr_q[c_tag_lo-1:c_idx_lo];
    assign w_fill_tag    = r_mc_addr_q[31:c_tag_lo];
    assign w_unused_addr = ^IF_addr[c_word_byte_bits-1:0];
    assign w_hit         = w_rd_valid && (w_rd_tag == w_req_tag);

    icache_line_ram #(
        .INDEX_WIDTH    (INDEX_WIDTH),
        .LINE_WORDS_LOG (LINE_WORDS_LOG),
        .TAG_WIDTH      (TAG_WIDTH)
    ) u_line_ram (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (w_req_index),
        .i_rd_offset (w_req_offset),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_word   (w_rd_word),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (w_fill_index),
        .i_wr_offset (r_cnt_q),
        .i_wr_data   (MC_data),
        .i_vld_clr   (w_vld_clr),
        .i_vld_set   (w_vld_set),
        .i_vld_index (w_vld_index),
        .i_set_tag   (w_fill_tag)
    );

    // Controller next state: lookup in IDLE, one-cycle RESPOND gap, word-by-word REFILL.
    always_comb begin
        w_state_d   = r_state_q;
        w_ins_sgn_d = 1'b0;
        w_ins_d     = r_ins_q;
        w_mc_req_d  = r_mc_req_q;
        w_mc_addr_d = r_mc_addr_q;
        w_cnt_d     = r_cnt_q;
        w_abort_d   = r_abort_q;
        w_wr_en     = 1'b0;
        w_vld_clr   = 1'b0;
        w_vld_set   = 1'b0;
        w_vld_index = w_fill_index;

        if (rdy) begin
            case (r_state_q)
                ST_IDLE: begin
                    if (IF_addr_sgn && !IF_pc_change) begin
                        if (w_hit) begin
                            w_ins_d     = w_rd_word;
                            w_ins_sgn_d = 1'b1;
                            w_state_d   = ST_RESPOND;
                        end else begin
                            // Invalidate up front so a partially refilled line never hits.
                            w_vld_clr   = 1'b1;
                            w_vld_index = w_req_index;
                            w_cnt_d     = '0;
                            w_mc_addr_d = {IF_addr[31:c_idx_lo], {c_idx_lo{1'b0}}};
                            w_mc_req_d  = 1'b1;
                            w_state_d   = ST_REFILL;
                        end
                    end
                end

                ST_RESPOND: begin
                    w_state_d = ST_IDLE;
                end

                ST_REFILL: begin
                    // A pc change only marks the refill as stale; the line is
                    // still completed so mem_ctrl never sees a cut transaction.
                    if (IF_pc_change) w_abort_d = 1'b1;
                    if (MC_done) begin
                        w_wr_en = 1'b1;
                        w_cnt_d = r_cnt_q + 1'b1;
                        if (r_cnt_q != c_last_word) begin
                            // Only the word-offset field advances: never leaves the line.
                            w_mc_addr_d = {r_mc_addr_q[31:c_idx_lo], w_cnt_d,
                                           {c_word_byte_bits{1'b0}}};
                        end else begin
                            w_mc_req_d = 1'b0;
                            w_vld_set  = 1'b1;
                            w_abort_d  = 1'b0;
                            w_state_d  = ST_IDLE;
                        end
                    end
                end

                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_ins_sgn_q <= 1'b0;
            r_ins_q     <= '0;
            r_mc_req_q  <= 1'b0;
            r_mc_addr_q <= '0;
            r_cnt_q     <= '0;
            r_abort_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_ins_sgn_q <= w_ins_sgn_d;
            r_ins_q     <= w_ins_d;
            r_mc_req_q  <= w_mc_req_d;
            r_mc_addr_q <= w_mc_addr_d;
            r_cnt_q     <= w_cnt_d;
            r_abort_q   <= w_abort_d;
        end
    end

    assign IF_ins_sgn = r_ins_sgn_q;
    assign IF_ins     = r_ins_q;
    assign MC_req     = r_mc_req_q;
    assign MC_addr    = r_mc_addr_q;

endmodule : icache

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  Module      : tb_icache
//  Description : Self-checking bench for icache: directed scenarios with
//                literal expectations plus randomized traffic compared each
//                cycle against a behavioural cache model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

    logic        clk = 1'b0;
    logic        rst, rdy, IF_addr_sgn, IF_pc_change, MC_done;
    logic [31:0] IF_addr, MC_data;
    logic        IF_ins_sgn, MC_req;
    logic [31:0] IF_ins, MC_addr;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: per-line valid/tag, memory content is a pure function.
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    int          m_mode  = 0;     // 0 lookup, 1 response gap, 2 filling a line
    logic [31:0] m_base  = '0;
    int          m_cnt   = 0;
    logic        m_sgn   = 1'b0;
    logic [31:0] m_ins   = '0;
    logic        m_req   = 1'b0;
    logic [31:0] m_addr  = '0;

    int          lat     = 1;
    bit          en_cmp  = 1'b0;
    logic [31:0] seen[$];
    int          pulses  = 0;
    logic [31:0] last_ins = '0;

    always #5 clk = ~clk;

    icache #(.INDEX_WIDTH(6), .LINE_WORDS_LOG(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .IF_addr      (IF_addr),
        .IF_addr_sgn  (IF_addr_sgn),
        .IF_pc_change (IF_pc_change),
        .IF_ins_sgn   (IF_ins_sgn),
        .IF_ins       (IF_ins),
        .MC_req       (MC_req),
        .MC_addr      (MC_addr),
        .MC_done      (MC_done),
        .MC_data      (MC_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare();
        chk("ins_sgn", {31'b0, IF_ins_sgn}, {31'b0, m_sgn});
        if (m_sgn) chk("ins", IF_ins, m_ins);
        chk("mc_req", {31'b0, MC_req}, {31'b0, m_req});
        if (m_req) chk("mc_addr", MC_addr, m_addr);
    endtask

    // Advance the model by one clock edge using the inputs about to be applied.
    task automatic model_step();
        int          idx;
        logic [21:0] tg;
        if (rst) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_mode = 0; m_sgn = 1'b0; m_ins = '0; m_req = 1'b0; m_addr = '0; m_cnt = 0;
        end else if (!rdy) begin
            m_sgn = 1'b0;
        end else begin
            m_sgn = 1'b0;
            case (m_mode)
                0: if (IF_addr_sgn && !IF_pc_change) begin
                    idx = int'((IF_addr >> 4) % 64);
                    tg  = 22'(IF_addr >> 10);
                    if (m_valid[idx] && m_tag[idx] == tg) begin
                        m_sgn  = 1'b1;
                        m_ins  = mem_word(IF_addr & 32'hFFFF_FFFC);
                        m_mode = 1;
                    end else begin
                        m_valid[idx] = 1'b0;
                        m_base = IF_addr & 32'hFFFF_FFF0;
                        m_cnt  = 0;
                        m_req  = 1'b1;
                        m_addr = m_base;
                        m_mode = 2;
                    end
                end
                1: m_mode = 0;
                default: if (MC_done) begin
                    m_cnt++;
                    if (m_cnt == 4) begin
                        idx = int'((m_base >> 4) % 64);
                        m_valid[idx] = 1'b1;
                        m_tag[idx]   = 22'(m_base >> 10);
                        m_req  = 1'b0;
                        m_mode = 0;
                    end else begin
                        m_addr = m_base + 32'(4 * m_cnt);
                    end
                end
            endcase
        end
    endtask

    // One clock: check outputs, play mem_ctrl, step model, advance to next negedge.
    task automatic tick();
        if (en_cmp) compare();
        MC_done = 1'b0;
        MC_data = '0;
        if (!rst && rdy && m_req) begin
            if (lat == 0) begin
                MC_done = 1'b1;
                MC_data = mem_word(m_addr);
                seen.push_back(MC_addr);
                lat = $urandom_range(0, 3);
            end else begin
                lat--;
            end
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (IF_ins_sgn) begin
            pulses++;
            last_ins = IF_ins;
        end
    endtask

    task automatic run_until_pulse(input int max_cycles);
        pulses = 0;
        for (int i = 0; i < max_cycles && pulses == 0; i++) tick();
        chk("pulse_seen", {31'b0, pulses != 0}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; IF_addr_sgn = 1'b0; IF_pc_change = 1'b0; rdy = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] tg;
        case ($urandom_range(0, 3))
            0: tg = 32'h0;
            1: tg = 32'h1;
            2: tg = 32'h2;
            default: tg = 32'h3F_FFFF;
        endcase
        return (tg << 10) | (32'($urandom_range(0, 3)) << 4) |
               (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; IF_addr = '0; IF_addr_sgn = 1'b0;
        IF_pc_change = 1'b0; MC_done = 1'b0; MC_data = '0;
        model_step();
        @(posedge clk);
        @(negedge clk);
        en_cmp = 1'b1;
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_ins_sgn", {31'b0, IF_ins_sgn}, 32'd0);
        chk("rst_ins", IF_ins, 32'd0);
        chk("rst_mc_req", {31'b0, MC_req}, 32'd0);
        chk("rst_mc_addr", MC_addr, 32'd0);

        // Cold miss on 0x0
        seen.delete();
        IF_addr = 32'h0; IF_addr_sgn = 1'b1;
        run_until_pulse(100);
        IF_addr_sgn = 1'b0;
        chk("cold_words", 32'(seen.size()), 32'd4);
        chk("cold_a0", seen[0], 32'h0);
        chk("cold_a3", seen[3], 32'hC);
        chk("cold_ins", last_ins, 32'hA5A5_0000);
        tick();
        chk("cold_gap", {31'b0, IF_ins_sgn}, 32'd0);

        // Hit on 0x8: one-cycle latency, no memory traffic, then a gap
        seen.delete();
        IF_addr = 32'h8; IF_addr_sgn = 1'b1;
        tick();
        chk("hit_sgn", {31'b0, IF_ins_sgn}, 32'd1);
        chk("hit_ins", IF_ins, 32'hA5A5_0008);
        IF_addr_sgn = 1'b0;
        tick();
        chk("hit_gap", {31'b0, IF_ins_sgn}, 32'd0);
        chk("hit_no_req", {31'b0, MC_req}, 32'd0);
        chk("hit_no_mc", 32'(seen.size()), 32'd0);

        // Conflict eviction on index 0
        IF_addr = 32'h400; IF_addr_sgn = 1'b1;
        run_until_pulse(100);
        IF_addr_sgn = 1'b0;
        chk("evict_a0", seen[0], 32'h400);
        chk("evict_ins", last_ins, 32'hA5A5_0400);
        tick();
        seen.delete();
        IF_addr = 32'h0; IF_addr_sgn = 1'b1;
        run_until_pulse(100);
        IF_addr_sgn = 1'b0;
        chk("refetch_a0", seen[0], 32'h0);
        chk("refetch_words", 32'(seen.size()), 32'd4);

        // Abort: pc change after the 2nd word, new address 0x104
        do_reset();
        seen.delete();
        IF_addr = 32'h100; IF_addr_sgn = 1'b1;
        for (int i = 0; i < 100 && seen.size() < 2; i++) tick();
        chk("abort_words", 32'(seen.size()), 32'd2);
        IF_pc_change = 1'b1; IF_addr = 32'h104;
        tick();
        IF_pc_change = 1'b0;
        run_until_pulse(100);
        IF_addr_sgn = 1'b0;
        chk("abort_ins", last_ins, 32'hA5A5_0104);
        chk("abort_words_total", 32'(seen.size()), 32'd4);
        tick();

        // Reset in the middle of a refill
        do_reset();
        seen.delete();
        IF_addr = 32'h200; IF_addr_sgn = 1'b1;
        for (int i = 0; i < 100 && seen.size() < 1; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_req", {31'b0, MC_req}, 32'd0);
        seen.delete();
        run_until_pulse(100);
        IF_addr_sgn = 1'b0;
        chk("rst_mid_a0", seen[0], 32'h200);
        chk("rst_mid_words", 32'(seen.size()), 32'd4);

        // Top-of-memory line: no overflow past 0xFFFFFFFC
        do_reset();
        seen.delete();
        IF_addr = 32'hFFFF_FFF0; IF_addr_sgn = 1'b1;
        run_until_pulse(100);
        IF_addr_sgn = 1'b0;
        chk("wrap_a0", seen[0], 32'hFFFF_FFF0);
        chk("wrap_a3", seen[3], 32'hFFFF_FFFC);
        chk("wrap_ins", last_ins, 32'h5A5A_FFF0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            rdy          = ($urandom_range(0, 9) != 0);
            IF_addr_sgn  = ($urandom_range(0, 7) != 0);
            IF_pc_change = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 3) IF_addr = rand_addr();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_icache

`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache. It is the responder for the instruction-fetch unit's fetch request interface.
- Accepts a word address plus request strobe from ifetch and returns one 32-bit instruction with a one-cycle valid pulse.
- On a miss it refills a whole line from the memory controller, one word per request.
- Sits between ifetch and mem_ctrl.

Parameters:
- INDEX_WIDTH, 6, number of index bits; the cache has 2^INDEX_WIDTH lines.
- LINE_WORDS_LOG, 2, log2 of 32-bit words per line (4 words = 16 B).
- TAG_WIDTH, 32-2-LINE_WORDS_LOG-INDEX_WIDTH (=22), derived; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = pause
- IF_addr  in  32  fetch address from ifetch; bits [1:0] ignored
- IF_addr_sgn  in  1  fetch request valid (low while ifetch stalls on JALR)
- IF_pc_change  in  1  ifetch pc just changed; any outstanding response is stale
- IF_ins_sgn  out  1  instruction valid pulse to ifetch
- IF_ins  out  32  instruction word
- MC_req  out  1  word read request to mem_ctrl
- MC_addr  out  32  word-aligned read address to mem_ctrl
- MC_done  in  1  one-cycle pulse: MC_data valid, request complete
- MC_data  in  32  word read from memory

Behaviour:
- Interface: reset is synchronous and active-high on rst; single clock clk.
- Address split: offset = addr[LINE_WORDS_LOG+1:2]; index = addr[INDEX_WIDTH+LINE_WORDS_LOG+1:LINE_WORDS_LOG+2]; tag = remaining upper bits.
- Storage: per line, one valid bit, TAG_WIDTH tag bits, and LINE_WORDS data words.
- Reset values:
  - all valid bits = 0
  - state = IDLE
  - IF_ins_sgn = 0, IF_ins = 0
  - MC_req = 0, MC_addr = 0
  - refill word counter = 0, abort flag = 0
- rdy low: state, counters, arrays and outputs all hold. IF_ins_sgn is forced to 0 in that cycle and no new pulse is generated.
- IDLE:
  - If IF_addr_sgn is high, IF_pc_change is low and the line hits: on the next edge IF_ins = data word and IF_ins_sgn = 1 (hit latency 1 cycle), then state = RESPOND.
  - On a miss under the same conditions: latch the line base {tag,index,0}, set counter = 0, MC_addr = base, MC_req = 1, state = REFILL.
  - If IF_addr_sgn is low or IF_pc_change is high: stay in IDLE, IF_ins_sgn = 0.
- RESPOND: lasts exactly one cycle. IF_ins_sgn drops to 0 and state returns to IDLE. This gap lets ifetch update its pc, so one address never produces two pulses.
- REFILL:
  - MC_req stays high and MC_addr stays stable until MC_done.
  - On MC_done: write MC_data into word[counter] of the indexed line and increment the counter.
  - If counter < LINE_WORDS-1: MC_addr += 4 and MC_req stays high.
  - Otherwise: MC_req = 0, write the tag, set valid = 1, state = IDLE. The subsequent IDLE lookup hits.
  - The valid bit of the line being refilled is cleared on REFILL entry, so a partial line is never hit.
- Abort: IF_pc_change high in any cycle while in REFILL sets an abort flag.
  - The refill still completes, so the mem_ctrl transaction is never cut.
  - On return to IDLE the flag is cleared and the lookup uses the current IF_addr.
  - No response is produced for the stale address.
- Simultaneous MC_done and IF_pc_change: the word is stored and the abort flag is set; both take effect.
- IF_pc_change on the same edge as an IDLE hit: the hit is suppressed and no pulse is given.
- rst mid-refill: everything returns to reset values on that edge. MC_req = 0 next cycle and the partial line stays invalid. mem_ctrl tolerates a dropped request.
- Wrap-around: the line base is aligned, so MC_addr increments never cross a line boundary. Address 0xFFFFFFF0 refills 0xFFFFFFF0..FC with no overflow.
- No writes from the core. Self-modifying code is unsupported.

Decomposition:
- defines.v holds the state encodings (IDLE/REFILL/RESPOND, 2 bits) and the TRUE/FALSE macros already shared.
- Sub-module icache_line_ram: tag/valid/data arrays with a combinational read port and one synchronous word-write port, plus a valid clear/set input. The FSM stays in icache.

Test Plan:
- Cold miss: reset, IF_addr=0x0, IF_addr_sgn=1; mem_ctrl returns 0x11,0x22,0x33,0x44 with 2-cycle latency -> MC_addr 0x0,0x4,0x8,0xC in order, then IF_ins=0x11 with a single IF_ins_sgn pulse.
- Hit after refill: IF_addr=0x8 -> IF_ins=0x33 one cycle after request, MC_req never rises; next-cycle IF_ins_sgn=0 (RESPOND gap).
- Conflict eviction: fill 0x0, then request 0x400 (same index 0, new tag) -> refill 0x400..0x40C; request 0x0 again -> miss, refill re-issued.
- Abort: miss on 0x100, pulse IF_pc_change after the 2nd MC_done, IF_addr becomes 0x104 -> line 0x100 completes, no pulse for 0x100, then IF_ins=word at 0x104 from the hit.
- Pause and JALR stall: rdy=0 for 5 cycles mid-refill -> MC_addr, MC_req and counter frozen and IF_ins_sgn=0; IF_addr_sgn=0 in IDLE -> no pulse, no MC_req.
- Reset mid-refill: assert rst after the 1st MC_done -> MC_req=0 next cycle; re-request the same address -> full miss again, MC_addr restarts at line base.
